// File: rtl/uart_tx_queue.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// uart_tx_queue : byte FIFO feeding a UART transmitter via send/donetx
// Revision      : 1.0
// ============================================================================
module uart_tx_queue #(
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 4096
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [7:0]             wr_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   send,
  output logic [7:0]             dintx,
  input  logic                   donetx,
  output logic                   busy,
  output logic                   timeout_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0] C_TMAX     = TW'(TIMEOUT - 1);
  localparam logic [AW:0]   C_FULL_CNT = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          meta_q, meta_d;
  logic          sync_q, sync_d;
  logic          prev_q, prev_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          send_q, send_d;
  logic [7:0]    dintx_q, dintx_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          terr_q, terr_d;
  logic [7:0]    mem_q [DEPTH];

  logic w_rise;
  logic w_pop;
  logic w_full;
  logic w_wr_acc;

  always_comb begin
    meta_d     = donetx;
    sync_d     = meta_q;
    prev_d     = sync_q;
    w_rise     = sync_q & ~prev_q;
    w_full     = (count_q == C_FULL_CNT);
    // A pop only ever happens from IDLE, so a full FIFO may accept a write then
    w_pop      = (state_q == IDLE) && (count_q != '0);
    w_wr_acc   = wr_en && (!w_full || w_pop);
    overflow_d = wr_en && w_full && !w_pop;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (w_wr_acc) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (w_wr_acc && !w_pop) begin
      count_d = count_q + (AW + 1)'(1);
    end else if (!w_wr_acc && w_pop) begin
      count_d = count_q - (AW + 1)'(1);
    end

    state_d = state_q;
    send_d  = send_q;
    dintx_d = dintx_q;
    timer_d = timer_q;
    terr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (w_pop) begin
          dintx_d = mem_q[rd_ptr_q];
          send_d  = 1'b1;
          timer_d = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (w_rise) begin
          send_d  = 1'b0;
          state_d = GAP;
        end else if (timer_q == C_TMAX) begin
          send_d  = 1'b0;
          terr_d  = 1'b1;
          state_d = GAP;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      GAP: begin
        // Transmitter must release donetx before the next byte is offered
        if (!sync_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      meta_q     <= 1'b0;
      sync_q     <= 1'b0;
      prev_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      send_q     <= 1'b0;
      dintx_q    <= 8'h00;
      timer_q    <= '0;
      terr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      meta_q     <= meta_d;
      sync_q     <= sync_d;
      prev_q     <= prev_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      send_q     <= send_d;
      dintx_q    <= dintx_d;
      timer_q    <= timer_d;
      terr_q     <= terr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_wr_acc) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign full        = w_full;
  assign empty       = (count_q == '0);
  assign count       = count_q;
  assign overflow    = overflow_q;
  assign send        = send_q;
  assign dintx       = dintx_q;
  assign busy        = (state_q != IDLE);
  assign timeout_err = terr_q;

endmodule
`default_nettype wire
